ws2812_pixel_rx: RTL

// - Parametrised WS2812b serial receiver. Measures each high pulse on one input line and classifies it as a 0 or 1 bit.
// - Assembles the bits MSB-first into GRB (24-bit) or GRBW (32-bit) pixel words and counts pixels within each frame.
// - Detects stream reset, runt pulses and over-long pulses.
// - Delivers pixels over a valid/ready handshake to the RGB->RGBW conversion stage. Runs at 96 MHz (PLL from 12 MHz).

---
 rtl/ws2812_pixel_rx_pkg.sv | 18 +
 rtl/ws_sync_edge.sv | 33 +++
 rtl/ws2812_pixel_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ws2812_pixel_rx_pkg.sv
// Shared timing constants (96 MHz clock) and receiver state encoding for the
// WS2812b pixel receiver.
package ws2812_pixel_rx_pkg;

  localparam int unsigned T0H_CLKS = 38;
  localparam int unsigned T1H_CLKS = 77;
  localparam int unsigned T0L_CLKS = 82;
  localparam int unsigned T1L_CLKS = 43;
  localparam int unsigned RES_CLKS = 4800;

  typedef enum logic [1:0] {
    ST_WAIT_RST = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2,
    ST_LOW      = 2'd3
  } ws_state_e;

endpackage

// File: rtl/ws_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus rising/falling edge
// decode against a delayed copy of the synchronised level.
module ws_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s2_d_r;

  // synchroniser chain and one-cycle delayed level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      s2_d_r <= 1'b0;
    end else begin
      s1_r   <= sig;
      s2_r   <= s1_r;
      s2_d_r <= s2_r;
    end
  end

  assign lvl  = s2_r;
  assign rise = s2_r & ~s2_d_r;
  assign fall = ~s2_r & s2_d_r;

endmodule

// File: rtl/ws2812_pixel_rx.sv
// WS2812b serial receiver: times each high pulse, assembles MSB-first pixel
// words, tracks the in-frame index and hands pixels out over valid/ready.
module ws2812_pixel_rx
  import ws2812_pixel_rx_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL    = 24,
  parameter int unsigned SAMPLE_TIME_CLKS  = 57,
  parameter int unsigned MIN_HIGH_CLKS     = 10,
  parameter int unsigned MAX_HIGH_CLKS     = 120,
  parameter int unsigned STREAM_RESET_CLKS = RES_CLKS,
  parameter int unsigned MAX_PIXELS        = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sig,
  output logic [BITS_PER_PIXEL-1:0]     pix_data,
  output logic [$clog2(MAX_PIXELS)-1:0] pix_idx,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          frame_start,
  output logic                          err_glitch,
  output logic                          err_overflow
);

  localparam int unsigned IDX_W = $clog2(MAX_PIXELS);
  localparam int unsigned LVL_W = $clog2(STREAM_RESET_CLKS + 1);
  localparam int unsigned BC_W  = $clog2(BITS_PER_PIXEL + 1);

  ws_state_e                 state_r;
  logic [LVL_W-1:0]          lvl_cnt_r;
  logic [BC_W-1:0]           bit_cnt_r;
  logic [BITS_PER_PIXEL-2:0] shreg_r;
  logic [IDX_W-1:0]          idx_r;

  logic                      lvl_s;
  logic                      rise_s;
  logic                      fall_s;
  logic                      stream_rst_s;
  logic                      accept_s;
  logic                      bit_s;
  logic                      pulse_ok_s;
  logic                      pix_done_s;
  logic [BITS_PER_PIXEL-1:0] pix_word_s;

  ws_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .sig  (sig),
    .lvl  (lvl_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // Fires on the single cycle the counter steps onto its saturation value.
  assign stream_rst_s = ~(rise_s | fall_s) &&
                        (lvl_cnt_r == LVL_W'(STREAM_RESET_CLKS - 1));
  assign accept_s     = pix_valid & pix_ready;
  assign pix_word_s   = {shreg_r, bit_s};

  // classify the high pulse that ends on this falling edge
  always_comb begin
    bit_s      = 1'b0;
    pulse_ok_s = 1'b0;
    pix_done_s = 1'b0;
    if ((state_r == ST_HIGH) && fall_s) begin
      bit_s      = (lvl_cnt_r >= LVL_W'(SAMPLE_TIME_CLKS));
      pulse_ok_s = (lvl_cnt_r >= LVL_W'(MIN_HIGH_CLKS)) &&
                   (lvl_cnt_r <= LVL_W'(MAX_HIGH_CLKS));
      pix_done_s = pulse_ok_s && (bit_cnt_r == BC_W'(BITS_PER_PIXEL - 1));
    end else begin
      bit_s      = 1'b0;
      pulse_ok_s = 1'b0;
      pix_done_s = 1'b0;
    end
  end

  // receiver FSM, level counter, bit assembly and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_WAIT_RST;
      lvl_cnt_r    <= '0;
      bit_cnt_r    <= '0;
      shreg_r      <= '0;
      idx_r        <= '0;
      pix_data     <= '0;
      pix_idx      <= '0;
      pix_valid    <= 1'b0;
      frame_start  <= 1'b0;
      err_glitch   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      frame_start  <= 1'b0;
      err_glitch   <= 1'b0;
      err_overflow <= 1'b0;

      if (rise_s | fall_s) begin
        lvl_cnt_r <= LVL_W'(1);
      end else if (lvl_cnt_r != LVL_W'(STREAM_RESET_CLKS)) begin
        lvl_cnt_r <= lvl_cnt_r + LVL_W'(1);
      end

      if (accept_s) begin
        pix_valid <= 1'b0;
      end

      if (stream_rst_s) begin
        frame_start <= 1'b1;
        bit_cnt_r   <= '0;
        shreg_r     <= '0;
        idx_r       <= '0;
        state_r     <= ST_IDLE;
      end else begin
        case (state_r)
          ST_WAIT_RST: state_r <= ST_WAIT_RST;
          ST_IDLE: begin
            if (rise_s) begin
              state_r <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (fall_s) begin
              if (!pulse_ok_s) begin
                err_glitch <= 1'b1;
                bit_cnt_r  <= '0;
                shreg_r    <= '0;
                state_r    <= ST_WAIT_RST;
              end else if (pix_done_s) begin
                bit_cnt_r <= '0;
                shreg_r   <= '0;
                if (idx_r != IDX_W'(MAX_PIXELS - 1)) begin
                  idx_r <= idx_r + IDX_W'(1);
                end
                // A pixel still held (and not taken this cycle) wins over the new one.
                if (!pix_valid || pix_ready) begin
                  pix_data  <= pix_word_s;
                  pix_idx   <= idx_r;
                  pix_valid <= 1'b1;
                end else begin
                  err_overflow <= 1'b1;
                end
                state_r <= ST_LOW;
              end else begin
                shreg_r   <= pix_word_s[BITS_PER_PIXEL-2:0];
                bit_cnt_r <= bit_cnt_r + BC_W'(1);
                state_r   <= ST_LOW;
              end
            end
          end
          // LOW is only entered on a falling edge, so a high level here is the next rise.
          ST_LOW: begin
            if (lvl_s) begin
              state_r <= ST_HIGH;
            end
          end
          default: state_r <= ST_WAIT_RST;
        endcase
      end
    end
  end

endmodule
